// File: rtl/result_packer_pkg.sv
// ============================================================================
// result_packer_pkg : shared widths, strobe constants and pack-state encoding
// Revision: 1.0
// ============================================================================
`default_nettype none

package result_packer_pkg;
    localparam int BEAT_W = 64;
    localparam int RES_W  = 32;
    localparam int STRB_W = BEAT_W / 8;
    localparam int FIFO_W = BEAT_W + STRB_W + 1;

    localparam logic [STRB_W-1:0] STRB_FULL = 8'hFF;
    localparam logic [STRB_W-1:0] STRB_LOW  = 8'h0F;

    typedef enum logic [0:0] {
        LOW  = 1'b0,
        HIGH = 1'b1
    } pack_state_e;
endpackage

`default_nettype wire

// File: rtl/result_packer_if.sv
// ============================================================================
// result_packer_if : AXI-Stream master channel of the result packer
// Revision: 1.0
// ============================================================================
`default_nettype none

interface result_packer_if;
    import result_packer_pkg::*;

    logic              TVALID;
    logic [BEAT_W-1:0] TDATA;
    logic [STRB_W-1:0] TSTRB;
    logic              TLAST;
    logic              TREADY;

    modport master (output TVALID, TDATA, TSTRB, TLAST, input TREADY);
    modport slave  (input TVALID, TDATA, TSTRB, TLAST, output TREADY);
endinterface

`default_nettype wire

// File: rtl/result_packer_sync_fifo.sv
// ============================================================================
// sync_fifo : fall-through synchronous FIFO; mark_last sets the top bit of the
//             most recently written entry
// Revision: 1.0
// ============================================================================
`default_nettype none

module sync_fifo #(
    parameter int WIDTH = 73,
    parameter int DEPTH = 16
) (
    input  wire logic                     clk,
    input  wire logic                     rst,
    input  wire logic                     push,
    input  wire logic                     pop,
    input  wire logic                     mark_last,
    input  wire logic [WIDTH-1:0]         din,
    output logic      [WIDTH-1:0]         dout,
    output logic                          empty,
    output logic                          full,
    output logic      [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             w_do_push;
    logic             w_do_pop;

    assign empty     = (count_q == '0);
    assign full      = (count_q == (AW+1)'(DEPTH));
    assign count     = count_q;
    assign dout      = mem_q[rd_ptr_q];
    // A full FIFO still accepts a write when the head leaves in the same cycle
    assign w_do_push = push & (~full | pop);
    assign w_do_pop  = pop & ~empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (w_do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (w_do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_q + {{AW{1'b0}}, w_do_push} - {{AW{1'b0}}, w_do_pop};
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            mem_q[wr_ptr_q] <= din;
        end else if (mark_last && !empty && !rst) begin
            mem_q[wr_ptr_q - AW'(1)][WIDTH-1] <= 1'b1;
        end
    end
endmodule

`default_nettype wire

// File: rtl/result_packer.sv
// ============================================================================
// result_packer : packs 32-bit results into 64-bit AXI-Stream beats with
//                 TLAST framing, end-of-run flush and FIFO back-pressure
// Revision: 1.0
// ============================================================================
`default_nettype none

module result_packer
    import result_packer_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int CNT_W = 8
) (
    input  wire logic             AXIS_ACLK,
    input  wire logic             AXIS_ARESETN,
    input  wire logic             run,
    input  wire logic             out_period,
    input  wire logic [RES_W-1:0] result,
    input  wire logic             s_fin,
    input  wire logic [CNT_W-1:0] words_per_frame,
    result_packer_if.master       m_axis,
    output logic                  stall,
    output logic                  overflow
);
    localparam int CW = $clog2(DEPTH) + 1;

    pack_state_e       state_q, state_d;
    logic [RES_W-1:0]  hold_q, hold_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              overflow_q;

    logic              w_clr;
    logic              w_push;
    logic              w_pop;
    logic              w_mark;
    logic              w_close;
    logic              w_flush_last;
    logic              w_frame_end;
    logic              w_last;
    logic [BEAT_W-1:0] w_beat;
    logic [STRB_W-1:0] w_strb;
    logic [FIFO_W-1:0] w_dout;
    logic              w_empty;
    logic              w_full;
    logic [CW-1:0]     w_count;

    assign w_clr = ~AXIS_ARESETN | ~run;
    assign w_pop = m_axis.TVALID & m_axis.TREADY;

    always_comb begin
        state_d      = state_q;
        hold_d       = hold_q;
        w_push       = 1'b0;
        w_beat       = '0;
        w_strb       = STRB_FULL;
        w_flush_last = 1'b0;
        w_mark       = 1'b0;
        w_close      = 1'b0;
        case (state_q)
            LOW: begin
                if (out_period) begin
                    hold_d = result;
                    if (s_fin) begin
                        w_push       = 1'b1;
                        w_beat       = {{RES_W{1'b0}}, result};
                        w_strb       = STRB_LOW;
                        w_flush_last = 1'b1;
                    end else begin
                        state_d = HIGH;
                    end
                end else if (s_fin && cnt_q != '0) begin
                    // Retro-tag the newest entry unless it is leaving this very cycle
                    w_close = 1'b1;
                    w_mark  = ~w_empty & ~((w_count == CW'(1)) & w_pop);
                end
            end
            HIGH: begin
                if (out_period) begin
                    w_push       = 1'b1;
                    w_beat       = {result, hold_q};
                    w_flush_last = s_fin;
                    state_d      = LOW;
                end else if (s_fin) begin
                    w_push       = 1'b1;
                    w_beat       = {{RES_W{1'b0}}, hold_q};
                    w_strb       = STRB_LOW;
                    w_flush_last = 1'b1;
                    state_d      = LOW;
                end
            end
            default: state_d = LOW;
        endcase

        w_frame_end = (words_per_frame != '0) && (cnt_q == words_per_frame - CNT_W'(1));
        w_last      = w_flush_last | w_frame_end;

        cnt_d = cnt_q;
        if (w_push) begin
            cnt_d = w_last ? '0 : cnt_q + CNT_W'(1);
        end else if (w_close) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge AXIS_ACLK) begin
        if (w_clr) begin
            state_q    <= LOW;
            hold_q     <= '0;
            cnt_q      <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            hold_q     <= hold_d;
            cnt_q      <= cnt_d;
            overflow_q <= overflow_q | (w_push & w_full & ~w_pop);
        end
    end

    sync_fifo #(
        .WIDTH (FIFO_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (AXIS_ACLK),
        .rst       (w_clr),
        .push      (w_push),
        .pop       (w_pop),
        .mark_last (w_mark),
        .din       ({w_last, w_strb, w_beat}),
        .dout      (w_dout),
        .empty     (w_empty),
        .full      (w_full),
        .count     (w_count)
    );

    assign m_axis.TVALID = ~w_empty;
    assign {m_axis.TLAST, m_axis.TSTRB, m_axis.TDATA} = w_empty ? '0 : w_dout;
    assign stall    = (w_count >= CW'(DEPTH - 2));
    assign overflow = overflow_q;
endmodule

`default_nettype wire

// File: doc/result_packer.md
Name: result_packer

Overview:
- Output stage between the core result path and the AXI-Stream master port.
- Takes the 32-bit per-cycle accumulator results qualified by out_period. Packs result pairs into 64-bit beats and buffers them in a FIFO.
- Drives M_AXIS_* with TLAST framing from a programmable beat count, and handles partial-beat flush at end of computation.
- Back-pressure from M_AXIS_TREADY is absorbed by the FIFO; `stall` warns the upstream control.

Parameters:
- DEPTH, 16, FIFO depth in 64-bit beats; power of two, minimum 4.
- CNT_W, 8, width of the frame beat counter and of words_per_frame.

Ports:
- AXIS_ACLK  in  1  clock.
- AXIS_ARESETN  in  1  synchronous active-low reset.
- run  in  1  soft enable; 0 synchronously clears the block exactly like reset.
- out_period  in  1  result[31:0] valid this cycle.
- result  in  32  accumulator word.
- s_fin  in  1  one-cycle pulse: computation finished, flush any partial beat and close the frame.
- words_per_frame  in  CNT_W  beats per frame; 0 means frames close only on s_fin.
- M_AXIS_TVALID  out  1  stream valid.
- M_AXIS_TDATA  out  64  stream data.
- M_AXIS_TSTRB  out  8  byte strobes.
- M_AXIS_TLAST  out  1  last beat of frame.
- M_AXIS_TREADY  in  1  downstream ready.
- stall  out  1  FIFO occupancy >= DEPTH-2.
- overflow  out  1  sticky: a beat was dropped because the FIFO was full.

Behaviour:
- Reset / run=0: all outputs 0, including TVALID, TLAST, stall and overflow. FIFO emptied, pack state LOW, beat counter 0. This applies mid-frame too: buffered data is discarded without a TLAST.
- Pack FSM, two states:
  - LOW: out_period latches result into hold[31:0], then goes to HIGH.
  - HIGH: out_period pushes beat {result, hold}, then goes to LOW. Word order: the first result is in the low half.
- Flush: s_fin in LOW with no out_period pushes nothing.
  - If the frame is open (counter != 0) and the FIFO is non-empty, the TLAST bit of the most recently pushed entry is set. This applies only while that entry has not yet been popped; otherwise nothing happens.
- Flush in HIGH: s_fin pushes {32'h0, hold} with TSTRB=8'h0F and TLAST=1, then goes to LOW.
- s_fin with out_period in the same cycle: the result is packed first.
  - If that completes a beat, the beat is pushed with TLAST=1.
  - If it leaves state HIGH, the half-beat is flushed immediately with TSTRB=8'h0F and TLAST=1.
- Every full beat has TSTRB=8'hFF.
- TLAST tagging: decided at push time and stored as extra FIFO bits (64 data + 8 strb + 1 last). The beat counter increments on each push.
  - When counter == words_per_frame-1 (and words_per_frame != 0), that beat gets TLAST=1 and the counter goes to 0.
  - Any push with TLAST=1 from flush also resets the counter to 0.
- FIFO: synchronous, first-word-fall-through registered output.
  - A beat pushed in cycle N is presented with TVALID=1 in cycle N+1 at the earliest.
  - Pop when TVALID & TREADY.
  - TDATA, TSTRB and TLAST stay stable while TVALID & ~TREADY.
- Full: a push with the FIFO full and no pop in the same cycle drops the beat and sets overflow; the counter still advances, so frame alignment is preserved.
  - Push and pop in the same cycle at full succeed.
  - Push and pop in the same cycle at empty: the beat appears in the next cycle.
- stall is combinational from the occupancy count; upstream deasserts out_period within two cycles of seeing it.
- Pointers wrap modulo DEPTH; occupancy counter width is clog2(DEPTH)+1.

Decomposition:
- Shared package: BEAT_W=64, RES_W=32, STRB_FULL=8'hFF, STRB_LOW=8'h0F, and the pack-state enum {LOW, HIGH}.
- One sub-module: sync_fifo (parameters WIDTH, DEPTH; ports push, pop, din, dout, empty, full, count). Instantiated with WIDTH=73.

Test Plan:
- words_per_frame=2, TREADY=1, results 1,2,3,4 on consecutive cycles -> beats 0x00000002_00000001 (TLAST=0), then 0x00000004_00000003 (TLAST=1); first TVALID one cycle after the push of beat 0.
- words_per_frame=0, results 5,6,7 then s_fin -> beat 0x00000006_00000005 TSTRB=FF TLAST=0, then 0x00000000_00000007 TSTRB=0F TLAST=1.
- TREADY=0, DEPTH=16, 40 results streamed -> stall rises when 14 beats are queued. The 17th through 20th beats are dropped, overflow=1, and the first 16 beats drain intact once TREADY=1.
- TVALID=1 with TREADY low for 5 cycles -> TDATA, TSTRB and TLAST unchanged across those cycles; single pop when TREADY rises.
- words_per_frame=3, 2 beats queued, run dropped to 0 for one cycle -> TVALID=0 next cycle, FIFO empty, counter 0. A new frame after run=1 carries TLAST on its 3rd beat.
- s_fin coincident with the 2nd result (words_per_frame=0) -> single beat {r2,r1}, TSTRB=FF, TLAST=1; no extra empty beat.
